fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo_sync_param.sv | 129 ++++++++++++
 tb/tb_fifo_sync_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, pointer-width helper and status bundle for the
// synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_WIDTH_DEF = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, sticky error flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through; default is a registered read.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  re,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ptr_w(FIFO_DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      occ;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] rdata;
  fifo_status_t          st;

  // Flags come only from registered pointers, so they never glitch.
  assign occ = wr_ptr_q - rd_ptr_q;

  assign st.full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign st.empty = (wr_ptr_q == rd_ptr_q);
  assign st.almost_full  = (occ >= PTR_W'(AF_LEVEL));
  assign st.almost_empty = (occ <= PTR_W'(AE_LEVEL));

  assign wr_acc = we & ~st.full  & ~clr;
  assign rd_acc = re & ~st.empty & ~clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      ovf_d = ovf_q | (we & st.full);
      udf_d = udf_q | (re & st.empty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WIDTH),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (rdata)
  );

`ifdef FIFO_FWFT_EN
  assign data_out = st.empty ? '0 : rdata;
`else
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (clr) begin
      dout_d = '0;
    end else if (rd_acc) begin
      dout_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
`endif

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign count        = occ;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param against a queue-based model.
module tb_fifo_sync_param;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             we  = 1'b0;
  logic             re  = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty;
  logic [4:0]       count;
  logic             overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;

  fifo_sync_param dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .we           (we),
    .data_in      (data_in),
    .re           (re),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (q.size() != 0) ? q[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".af"},    32'(almost_full),  32'(q.size() >= AF));
    chk({tag, ".ae"},    32'(almost_empty), 32'(q.size() <= AE));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
    chk({tag, ".udf"},   32'(underflow), 32'(m_udf));
    chk({tag, ".dout"},  32'(data_out),  32'(exp_dout()));
  endtask

  task automatic model_edge(input logic w, input logic r,
                            input logic [WIDTH-1:0] d, input logic c);
    int  sz;
    logic wa, ra;
    if (c) begin
      q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_dout = '0;
    end else begin
      sz = q.size();
      wa = w && (sz != DEPTH);
      ra = r && (sz != 0);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_udf = 1'b1;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    we = w; re = r; data_in = d; clr = c;
    @(posedge clk);
    model_edge(w, r, d, c);
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_dout = '0;
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    // Reset state
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // 1: fill 0x01..0x10, then overflow
    for (int i = 1; i <= 16; i++) step("fill", 1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill.full_direct", 32'(full), 32'd1);
    step("ovf_wr", 1'b1, 1'b0, 8'h77, 1'b0);
    chk("ovf_direct", 32'(overflow), 32'd1);

    // 2: drain, then underflow with data_out held
    for (int i = 1; i <= 16; i++) step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("drain.last_word", 32'(data_out), 32'h10);
`endif
    step("udf_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_direct", 32'(underflow), 32'd1);

    // 3: count 5, simultaneous read+write across pointer wrap
    step("clr3", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step("pre5", 1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++)
      step("rw", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);

    // 5: count 10 with overflow, then clr with we=re=1
    while (q.size() < DEPTH) step("fill5", 1'b1, 1'b0, 8'($urandom), 1'b0);
    step("ovf5", 1'b1, 1'b0, 8'hEE, 1'b0);
    for (int i = 0; i < 6; i++) step("to10", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("pre_clr.count", 32'(count), 32'd10);
    step("clr5", 1'b1, 1'b1, 8'h99, 1'b1);
    step("idle5", 1'b0, 1'b0, 8'h00, 1'b0);

    // 4: async reset between edges
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    step("pre_rst_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    rst = 1'b1;
    step("wr_aa", 1'b1, 1'b0, 8'hAA, 1'b0);
    step("rd_aa", 1'b0, 1'b1, 8'h00, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("aa_direct", 32'(data_out), 32'hAA);
`endif

`ifdef FIFO_FWFT_EN
    // 6: fall-through
    step("fw_wr", 1'b1, 1'b0, 8'h5A, 1'b0);
    chk("fw_dout", 32'(data_out), 32'h5A);
    step("fw_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("fw_empty", 32'(data_out), 32'h0);
`endif

    // Random phases biased toward filling then draining
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 40; i++) begin
        int wp;
        wp = (ph % 2 == 0) ? 75 : 25;
        v = 8'($urandom);
        step("rand",
             ($urandom_range(99) < wp),
             ($urandom_range(99) < (100 - wp)),
             v,
             ($urandom_range(63) == 0));
      end
    end

    step("final", 1'b0, 1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
